// File: rtl/shift_arbiter.sv
// shift_arbiter: two requesters share one combinational shifter (SLL/SRL/SRA/pass)
// through round-robin arbitration and a single registered result stage.
// The result stage forwards on drain, so back-to-back operations sustain one per cycle.
//
// Ports:
//   clk, rst_n                  clock (rising edge) and asynchronous active-low reset
//   req{0,1}_valid/ready        request handshake; ready is combinational and forced low in reset
//   req{0,1}_op                 00 SLL, 01 SRL, 10 SRA, 11 pass-through
//   req{0,1}_data, _shamt       operand and shift amount
//   res_valid/res_ready         result handshake
//   res_data, res_id            registered shift result and the requester that issued it
//   grant_cnt0, grant_cnt1      saturating accepted-op counters
//
// Optional feature: define SHIFT_ARBITER_GRANT_CNT_EN to implement the grant counters.
// When it is undefined, both counters read 16'h0000.
module shift_arbiter #(
    parameter int unsigned N = 32,
    localparam int unsigned SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [1:0]    req0_op,
    input  logic [N-1:0]  req0_data,
    input  logic [SW-1:0] req0_shamt,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [1:0]    req1_op,
    input  logic [N-1:0]  req1_data,
    input  logic [SW-1:0] req1_shamt,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [N-1:0]  res_data,
    output logic          res_id,
    output logic [15:0]   grant_cnt0,
    output logic [15:0]   grant_cnt1
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    res_data_q, res_data_d;
    logic            res_id_q, res_id_d;
    logic            last_grant_q, last_grant_d;

    logic            can_accept;
    logic            grant_vld;
    logic            grant_id;
    logic            accept;
    logic [1:0]      sel_op;
    logic [N-1:0]    sel_data;
    logic [SW-1:0]   sel_shamt;
    logic [N-1:0]    shift_out;

    // Shared shift datapath
    function automatic logic [N-1:0] do_shift(input logic [1:0] op,
                                              input logic [N-1:0] d,
                                              input logic [SW-1:0] s);
        case (op)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return N'($signed(d) >>> s);
            default: return d;
        endcase
    endfunction

    // Round-robin grant: on a tie the requester not served last wins
    always_comb begin
        grant_vld = req0_valid | req1_valid;
        grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant_q;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    // A full stage can take a new op in the same cycle its result drains
    assign can_accept = (state_q == EMPTY) || res_ready;
    assign accept     = rst_n && can_accept && grant_vld;

    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept &&  grant_id;

    // Operand mux feeding the single shifter
    always_comb begin
        sel_op    = grant_id ? req1_op    : req0_op;
        sel_data  = grant_id ? req1_data  : req0_data;
        sel_shamt = grant_id ? req1_shamt : req0_shamt;
        shift_out = do_shift(sel_op, sel_data, sel_shamt);
    end

    // Next-state and result-stage load
    always_comb begin
        state_d      = state_q;
        res_data_d   = res_data_q;
        res_id_d     = res_id_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            state_d      = FULL;
            res_data_d   = shift_out;
            res_id_d     = grant_id;
            last_grant_d = grant_id;
        end else if (state_q == FULL && res_ready) begin
            state_d = EMPTY;
        end
    end

    // State and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            res_data_q   <= '0;
            res_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            res_data_q   <= res_data_d;
            res_id_q     <= res_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign res_valid = (state_q == FULL);
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;

`ifdef SHIFT_ARBITER_GRANT_CNT_EN
    logic [15:0] cnt0_q, cnt1_q;

    // Saturating per-requester accept counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= 16'h0000;
            cnt1_q <= 16'h0000;
        end else begin
            if (req0_ready && cnt0_q != 16'hFFFF) cnt0_q <= cnt0_q + 16'd1;
            if (req1_ready && cnt1_q != 16'hFFFF) cnt1_q <= cnt1_q + 16'd1;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`else
    assign grant_cnt0 = 16'h0000;
    assign grant_cnt1 = 16'h0000;
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter: the driver pushes hand-computed results when
// it expects an accept; a negedge monitor pops and compares on every result handshake.
module tb_shift_arbiter;

    localparam logic [1:0] SLL  = 2'b00;
    localparam logic [1:0] SRL  = 2'b01;
    localparam logic [1:0] SRA  = 2'b10;
    localparam logic [1:0] PASS = 2'b11;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [31:0] req0_data, req1_data;
    logic [4:0]  req0_shamt, req1_shamt;
    logic        res_valid, res_ready, res_id;
    logic [31:0] res_data;
    logic [15:0] grant_cnt0, grant_cnt1;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    shift_arbiter #(.N(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_data  (req0_data),
        .req0_shamt (req0_shamt),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_data  (req1_data),
        .req1_shamt (req1_shamt),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Result monitor
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got id=%0d data=%h with empty scoreboard", res_id, res_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res_data", res_data, e.data);
                chk("res_id", 32'(res_id), 32'(e.id));
            end
        end
    end

    // One clock of stimulus; expected readys and results are supplied by the caller
    task automatic cycle(input logic v0, input logic [1:0] o0, input logic [31:0] d0, input logic [4:0] s0,
                         input logic v1, input logic [1:0] o1, input logic [31:0] d1, input logic [4:0] s1,
                         input logic rr, input logic e0, input logic e1,
                         input logic [31:0] x0, input logic [31:0] x1);
        @(posedge clk);
        #1;
        req0_valid = v0; req0_op = o0; req0_data = d0; req0_shamt = s0;
        req1_valid = v1; req1_op = o1; req1_data = d1; req1_shamt = s1;
        res_ready  = rr;
        @(negedge clk);
        chk("req0_ready", 32'(req0_ready), 32'(e0));
        chk("req1_ready", 32'(req1_ready), 32'(e1));
        if (e0) sb.push_back('{id: 1'b0, data: x0});
        if (e1) sb.push_back('{id: 1'b1, data: x1});
    endtask

    task automatic idle(input logic rr);
        cycle(1'b0, SLL, 32'h0, 5'd0, 1'b0, SLL, 32'h0, 5'd0, rr, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset: readys must stay low even with requests pending
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_op = SLL; req0_data = 32'h1; req0_shamt = 5'd1;
        req1_valid = 1'b1; req1_op = SLL; req1_data = 32'h1; req1_shamt = 5'd1;
        res_ready = 1'b1;
        @(negedge clk);
        chk("rst_res_valid", 32'(res_valid), 32'h0);
        chk("rst_res_data", res_data, 32'h0);
        chk("rst_res_id", 32'(res_id), 32'h0);
        chk("rst_req0_ready", 32'(req0_ready), 32'h0);
        chk("rst_req1_ready", 32'(req1_ready), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // SLL 1 by 31
        cycle(1'b1, SLL, 32'h0000_0001, 5'd31, 1'b0, SLL, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'h0);
        idle(1'b1);
        chk("t1_res_valid", 32'(res_valid), 32'h1);

        // req1 SRA then SRL back-to-back
        cycle(1'b0, SLL, 32'h0, 5'd0, 1'b1, SRA, 32'h8000_0000, 5'd4, 1'b1, 1'b0, 1'b1, 32'h0, 32'hF800_0000);
        cycle(1'b0, SLL, 32'h0, 5'd0, 1'b1, SRL, 32'h8000_0000, 5'd4, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0800_0000);
        idle(1'b1);

        // Both valid for 6 cycles: alternate starting with requester 0
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, SLL, 32'h0000_00F0, 5'd4, 1'b1, SRL, 32'hF000_0000, 5'd4, 1'b1,
                  (i % 2) == 0, (i % 2) == 1, 32'h0000_0F00, 32'h0F00_0000);
            chk("t3_onehot", 32'(req0_ready & req1_ready), 32'h0);
        end
        idle(1'b1);

        // Stall: result held, no readys while res_ready low
        cycle(1'b1, SRA, 32'h8000_0001, 5'd1, 1'b0, SLL, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 32'hC000_0000, 32'h0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, PASS, 32'h1234_5678, 5'd0, 1'b1, SLL, 32'h1, 5'd1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            chk("stall_res_valid", 32'(res_valid), 32'h1);
            chk("stall_res_data", res_data, 32'hC000_0000);
            chk("stall_res_id", 32'(res_id), 32'h0);
        end
        // Drain and accept in the same cycle; requester 1 wins the tie
        cycle(1'b1, PASS, 32'h1234_5678, 5'd0, 1'b1, SLL, 32'h1, 5'd1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_0002);
        cycle(1'b1, PASS, 32'h1234_5678, 5'd0, 1'b0, SLL, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h1234_5678, 32'h0);
        idle(1'b1);

        // Pass-through ignores shamt; zero shift returns the operand
        cycle(1'b0, SLL, 32'h0, 5'd0, 1'b1, PASS, 32'hDEAD_BEEF, 5'd7, 1'b1, 1'b0, 1'b1, 32'h0, 32'hDEAD_BEEF);
        cycle(1'b0, SLL, 32'h0, 5'd0, 1'b1, SRL, 32'hDEAD_BEEF, 5'd0, 1'b1, 1'b0, 1'b1, 32'h0, 32'hDEAD_BEEF);
        idle(1'b1);

        // Reset while full: pending result is discarded immediately
        cycle(1'b1, SLL, 32'h3, 5'd1, 1'b0, SLL, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h6, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_res_valid", 32'(res_valid), 32'h0);
        chk("midrst_req0_ready", 32'(req0_ready), 32'h0);
        chk("midrst_cnt0", 32'(grant_cnt0), 32'h0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_res_valid", 32'(res_valid), 32'h0);

        // Three req0 and two req1 accepts
        cycle(1'b1, SLL, 32'h1, 5'd1, 1'b0, SLL, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h2, 32'h0);
        cycle(1'b1, SLL, 32'h1, 5'd2, 1'b0, SLL, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h4, 32'h0);
        cycle(1'b1, SLL, 32'h1, 5'd3, 1'b0, SLL, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h8, 32'h0);
        cycle(1'b0, SLL, 32'h0, 5'd0, 1'b1, SRL, 32'h8000_0000, 5'd1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h4000_0000);
        cycle(1'b0, SLL, 32'h0, 5'd0, 1'b1, SRL, 32'h8000_0000, 5'd2, 1'b1, 1'b0, 1'b1, 32'h0, 32'h2000_0000);
        idle(1'b1);
`ifdef SHIFT_ARBITER_GRANT_CNT_EN
        chk("grant_cnt0", 32'(grant_cnt0), 32'd3);
        chk("grant_cnt1", 32'(grant_cnt1), 32'd2);
`else
        chk("grant_cnt0", 32'(grant_cnt0), 32'd0);
        chk("grant_cnt1", 32'(grant_cnt1), 32'd0);
`endif
        idle(1'b1);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("final_res_valid", 32'(res_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one combinational shift datapath (sll/srl/sra, N bits) between two requesters, e.g. the ALU issue path and the load/store byte-alignment path in the rv32i core.
- Round-robin arbitration, valid/ready handshakes on both sides, one registered result stage with requester ID tag.
- Exactly one operation in flight; results return in request-acceptance order.

Parameters:
- N, 32, datapath width; power of two, >= 8.
- SW, $clog2(N), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 pass-through.
- req0_data  input  N  operand.
- req0_shamt  input  SW  shift amount.
- req1_valid, req1_ready, req1_op, req1_data, req1_shamt: same as requester 0.
- res_valid  output  1  result register holds an unconsumed result.
- res_ready  input  1  consumer accepts result.
- res_data  output  N  shift result.
- res_id  output  1  requester that issued the result.
- grant_cnt0  output  16  requester 0 accepted-op count (feature-gated).
- grant_cnt1  output  16  requester 1 accepted-op count (feature-gated).

Behaviour:
- Reset (rst_n low, asynchronous): res_valid=0, res_data=0, res_id=0, last_grant=1 (requester 0 wins first tie), grant counters=0. req*_ready combinationally 0 while rst_n low.
- States: EMPTY (res_valid=0), FULL (res_valid=1).
- can_accept = EMPTY | (FULL & res_ready): single-entry pipeline with bypass-on-drain, so back-to-back ops sustain 1 op/cycle.
- Arbitration (combinational): only req0 valid -> grant 0; only req1 valid -> grant 1; both -> grant !last_grant; none -> no grant.
- reqX_ready = can_accept & grant==X; never asserted for a non-valid requester; at most one ready per cycle.
- Accept cycle T (valid & ready): shifter computes from the granted operands; at edge end of T res_data/res_id load, res_valid=1, last_grant=X. Latency: result visible cycle T+1.
- EMPTY: no accept -> stays EMPTY; accept -> FULL.
- FULL: res_ready=0 -> hold res_data/res_id stable, no req_ready; res_ready=1 and accept -> stays FULL with new result; res_ready=1, no accept -> EMPTY, res_data keeps last value.
- Arithmetic: SLL zero-fill left; SRL zero-fill right; SRA sign-fill from data[N-1]; shamt=0 returns operand unchanged; op 11 returns operand unchanged, shamt ignored.
- Requesters must hold valid/op/data/shamt stable until ready; arbiter registers no request-side state except last_grant, so a dropped valid before grant is simply lost.
- Reset mid-operation: pending result discarded, no ready/valid glitch after rst_n deasserts; first cycle after release behaves as EMPTY.

Optional Feature:
- Macro SHIFT_ARBITER_GRANT_CNT_EN.
- Defined: grant_cnt0/grant_cnt1 increment by 1 on each accepted op of that requester, saturate at 16'hFFFF, reset to 0.
- Undefined: counters not implemented; grant_cnt0/grant_cnt1 tied to 16'h0000; all other behaviour identical.

Test Plan:
- Reset then req0 SLL data=32'h0000_0001 shamt=31, res_ready=1 -> req0_ready cycle 0, res_valid=1 next cycle, res_data=32'h8000_0000, res_id=0.
- req1 SRA data=32'h8000_0000 shamt=4 then SRL same operands -> res_data 32'hF800_0000 then 32'h0800_0000, res_id=1, one result per cycle.
- Both valid continuously, res_ready=1, 6 cycles -> grants 0,1,0,1,0,1; res_id sequence matches; never both readys high.
- res_ready=0 for 5 cycles after one accept -> res_valid=1, res_data/res_id constant, req0_ready=req1_ready=0 throughout; raising res_ready with pending req accepts same cycle.
- op=11 data=32'hDEAD_BEEF shamt=7; op=SRL shamt=0 -> both return 32'hDEAD_BEEF.
- rst_n low while FULL -> res_valid 0 immediately; with SHIFT_ARBITER_GRANT_CNT_EN, 3 req0 and 2 req1 accepts -> grant_cnt0=3, grant_cnt1=2; without macro both read 0.
